dmem_access_ctrl: RTL and testbench

//  Load/store sequencer between the RV32I MEM stage and Data_Memory (512x32, multi-cycle read, Ready handshake).

---
 rtl/dmem_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the RV32I MEM stage and a multi-cycle Data_Memory.
// Handles word/sub-word loads, read-modify-write sub-word stores, and error and timeout reporting.
module dmem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0]  TIMEOUT_LAST = 4'(TIMEOUT - 1);
    localparam logic [31:0] ADDR_LIMIT   = 32'(MEM_BYTES);

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [3:0]  timer;

    // Illegal funct3, out-of-range address, or misaligned halfword/word access.
    function automatic logic req_error(input logic        we,
                                       input logic [2:0]  f3,
                                       input logic [31:0] addr);
        logic bad_f3;
        logic bad_align;
        bad_f3    = 1'b0;
        bad_align = 1'b0;
        if (we) begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                       f3 == F3_BU || f3 == F3_HU);
        end
        case (f3)
            F3_H, F3_HU: bad_align = addr[0];
            F3_W:        bad_align = (addr[1:0] != 2'b00);
            default:     bad_align = 1'b0;
        endcase
        return bad_f3 || bad_align || (addr >= ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_BU:   result = {24'h000000, byte_v};
            F3_HU:   result = {16'h0000, half_v};
            default: result = word;
        endcase
        return result;
    endfunction

    // Only the addressed lane(s) change; the rest keep the value just read.
    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [15:0] data);
        logic [31:0] merged;
        merged = old_word;
        case (f3)
            F3_B:    merged[{lane, 3'b000} +: 8] = data[7:0];
            F3_H:    merged[{lane[1], 4'b0000} +: 16] = data;
            default: merged = old_word;
        endcase
        return merged;
    endfunction

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0000;
            timer       <= 4'h0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            mem_address <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        lane_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        timer       <= 4'h0;
                        mem_address <= {req_addr[31:2], 2'b00};
                        resp_rdata  <= 32'h0;
                        resp_err    <= 1'b0;
                        if (req_error(req_we, req_funct3, req_addr)) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_funct3 == F3_W) begin
                            mem_wdata <= req_wdata;
                            mem_write <= 1'b1;
                            state     <= WR;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        if (we_q) begin
                            mem_wdata <= store_merge(funct3_q, lane_q, mem_rdata, wdata_q);
                            mem_write <= 1'b1;
                            state     <= WR;
                        end else begin
                            resp_rdata <= load_extract(funct3_q, lane_q, mem_rdata);
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else if (timer == TIMEOUT_LAST) begin
                        mem_read   <= 1'b0;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        timer <= timer + 4'h1;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // Guarantees MemRead is low for a cycle so the memory's ready counter restarts.
                    mem_read <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl with a Data_Memory model (Ready on the 3rd MemRead edge)
// and a response scoreboard.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int write_cnt = 0;
    int read_cnt = 0;

    logic [31:0] mem [0:511];
    logic [1:0]  rd_cnt = 2'd0;
    logic        ready_r = 1'b0;
    logic        force_low = 1'b0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          accept;
    } exp_t;

    exp_t sb_q[$];

    dmem_access_ctrl #(.MEM_BYTES(2048), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Data_Memory model: Ready rises on the 3rd consecutive MemRead edge, clears when MemRead drops.
    assign mem_rdata = mem[mem_address[10:2]];
    assign mem_ready = ready_r & ~force_low;

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[10:2]] <= mem_wdata;
        if (!mem_read) begin
            rd_cnt  <= 2'd0;
            ready_r <= 1'b0;
        end else begin
            if (rd_cnt == 2'd2) ready_r <= 1'b1;
            if (rd_cnt != 2'd3) rd_cnt <= rd_cnt + 2'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write) write_cnt++;
        if (mem_read) read_cnt++;
        if (rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_rdata"}, resp_rdata, e.rdata);
                check({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                check({e.tag, "_latency"}, 32'(cycle - e.accept + 1), 32'(e.lat));
            end
        end
    end

    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input int exp_writes, input logic exp_reads);
        int n;
        int w0;
        int r0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        w0 = write_cnt;
        r0 = read_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb_q.push_back('{tag, exp_rdata, exp_err, exp_lat, cycle});
        check({tag, "_mem_address"}, mem_address, {addr[31:2], 2'b00});
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed pending %0d expected 0", tag, sb_q.size());
        end
        sb_q.delete();
        check({tag, "_writes"}, 32'(write_cnt - w0), 32'(exp_writes));
        check({tag, "_read_seen"}, {31'd0, (read_cnt != r0)}, {31'd0, exp_reads});
        check({tag, "_mem_read_low"}, {31'd0, mem_read}, 32'd0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_mem_read", {31'd0, mem_read}, 32'd0);
        check("reset_mem_write", {31'd0, mem_write}, 32'd0);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_mem_address", mem_address, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1'b0);
        applyStimulus("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 0, 1'b1);
        applyStimulus("sb_11",  1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0, 6, 1, 1'b1);
        applyStimulus("lw_sb",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, 5, 0, 1'b1);
        applyStimulus("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 5, 0, 1'b1);
        applyStimulus("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 5, 0, 1'b1);
        applyStimulus("sh_12",  1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 6, 1, 1'b1);
        applyStimulus("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0, 5, 0, 1'b1);
        applyStimulus("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AAEF, 1'b0, 5, 0, 1'b1);
        applyStimulus("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b0, 5, 0, 1'b1);
        applyStimulus("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'h00000012, 1'b0, 5, 0, 1'b1);
        applyStimulus("lw_sh",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 5, 0, 1'b1);

        applyStimulus("err_lh_13",  1'b0, 3'b001, 32'h13,  32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        applyStimulus("err_sw_12",  1'b1, 3'b010, 32'h12,  32'h5555AAAA, 32'h0, 1'b1, 1, 0, 1'b0);
        applyStimulus("err_lw_800", 1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        applyStimulus("err_f3_011", 1'b0, 3'b011, 32'h0,   32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        applyStimulus("err_sf3_100", 1'b1, 3'b100, 32'h0,  32'h0, 32'h0, 1'b1, 1, 0, 1'b0);

        force_low = 1'b1;
        applyStimulus("timeout_lw", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b1, TIMEOUT + 1, 0, 1'b1);
        force_low = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a sub-word store's read phase must abort without writing.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000055;
        w0 = write_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_abort_mem_read_before", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_abort_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_abort_mem_address", mem_address, 32'h0);
        check("rst_abort_mem_wdata", mem_wdata, 32'h0);
        check("rst_abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_abort_no_write", 32'(write_cnt - w0), 32'd0);
        applyStimulus("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 5, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
